// File: rtl/exec_sequencer_pkg.sv
// Shared MIPS control definitions: opcode/funct encodings, sequencer states,
// instruction classes and the pc_src / reg_dst select encodings.
package cpu_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [2:0] OP_IALU_HI = 3'b001;

    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [2:0] FN_SHIFT_HI = 3'b000;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_e;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_REG    = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        RD_RT = 2'b00,
        RD_RD = 2'b01,
        RD_RA = 2'b10
    } reg_dst_e;

    typedef enum logic [3:0] {
        CLS_R_ALU,
        CLS_SHIFT,
        CLS_I_ALU,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_BNE,
        CLS_J,
        CLS_JAL,
        CLS_JR,
        CLS_ILLEGAL
    } instr_class_e;

    function automatic logic is_r_alu_funct(input logic [5:0] funct);
        case (funct)
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND,
            FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Unified memory port handshake: request/write held by the sequencer until ack.
interface exec_sequencer_if;
    logic mem_req;
    logic mem_we;
    logic mem_ack;

    modport master (output mem_req, output mem_we, input mem_ack);
    modport slave  (input mem_req, input mem_we, output mem_ack);
endinterface

// File: rtl/exec_sequencer_decode.sv
// Combinational classification of the latched instruction into one of the
// classes the sequencer distinguishes; anything unsupported is CLS_ILLEGAL.
module instr_class_decode
    import cpu_defs::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_e instr_class
);

    always_comb begin
        // NOTE: assign every always_comb output a default before any branch,
        // otherwise an uncovered path infers a latch.
        instr_class = CLS_ILLEGAL;
        if (opcode == OP_RTYPE) begin
            if (funct == FN_JR) begin
                instr_class = CLS_JR;
            end else if (funct[5:3] == FN_SHIFT_HI) begin
                instr_class = CLS_SHIFT;
            end else if (is_r_alu_funct(funct)) begin
                instr_class = CLS_R_ALU;
            end
        end else if (opcode[5:3] == OP_IALU_HI) begin
            instr_class = CLS_I_ALU;
        end else begin
            case (opcode)
                OP_J:    instr_class = CLS_J;
                OP_JAL:  instr_class = CLS_JAL;
                OP_BEQ:  instr_class = CLS_BEQ;
                OP_BNE:  instr_class = CLS_BNE;
                OP_LW:   instr_class = CLS_LW;
                OP_SW:   instr_class = CLS_SW;
                default: instr_class = CLS_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle MIPS control sequencer: fetch over the memory handshake, then
// drive ALU, register-file and PC controls for 2-5 cycles per instruction.
module exec_sequencer
    import cpu_defs::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    exec_sequencer_if.master   mem,
    output logic               ir_write,
    output logic [1:0]         alu_op,
    output logic               alu_src,
    output logic               sftmd,
    output logic               i_format,
    output logic               jr,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic               mem_to_reg,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               instr_retired,
    output logic [COUNT_W-1:0] retired_count,
    output logic               illegal
);

    state_e       state_q, state_d;
    instr_class_e cls;
    pc_src_e      pc_src_c;
    reg_dst_e     reg_dst_c;
    logic         run_q;
    logic         mem_req_c, mem_we_c;
    logic         set_illegal;
    logic         is_r_type, is_i_alu, is_branch, take_branch, alu_stage;

    instr_class_decode u_decode (
        .opcode      (opcode),
        .funct       (funct),
        .instr_class (cls)
    );

    assign is_r_type   = cls inside {CLS_R_ALU, CLS_SHIFT, CLS_JR};
    assign is_i_alu    = (cls == CLS_I_ALU);
    assign is_branch   = cls inside {CLS_BEQ, CLS_BNE};
    assign take_branch = ((cls == CLS_BEQ) && zero) || ((cls == CLS_BNE) && !zero);

    // ALU controls depend only on the stable IR, so they hold from EXEC to WB.
    assign alu_stage = run_q && (state_q inside {S_EXEC, S_MEM, S_WB});
    assign alu_op    = alu_stage ? {is_r_type || is_i_alu, is_branch} : 2'b00;
    assign alu_src   = alu_stage && (is_i_alu || (cls inside {CLS_LW, CLS_SW}));
    assign sftmd     = alu_stage && (cls == CLS_SHIFT);
    assign i_format  = alu_stage && is_i_alu;
    assign jr        = alu_stage && (cls == CLS_JR);

    always_comb begin
        state_d     = state_q;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst_c   = RD_RT;
        mem_to_reg  = 1'b0;
        pc_write    = 1'b0;
        pc_src_c    = PC_SEQ;
        set_illegal = 1'b0;
        // run_q is low for the cycle after a reset edge: outputs stay quiet
        // and a late mem_ack from an aborted request cannot advance the FSM.
        if (run_q) begin
            case (state_q)
                S_FETCH: begin
                    mem_req_c = 1'b1;
                    if (mem.mem_ack) begin
                        ir_write = 1'b1;
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (cls)
                        CLS_J: begin
                            pc_write = 1'b1;
                            pc_src_c = PC_JUMP;
                            state_d  = S_FETCH;
                        end
                        CLS_JAL: state_d = S_WB;
                        CLS_ILLEGAL: begin
                            set_illegal = 1'b1;
                            pc_write    = 1'b1;
                            state_d     = S_FETCH;
                        end
                        default: state_d = S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    case (cls)
                        CLS_LW, CLS_SW: state_d = S_MEM;
                        CLS_BEQ, CLS_BNE: begin
                            pc_write = 1'b1;
                            pc_src_c = take_branch ? PC_BRANCH : PC_SEQ;
                            state_d  = S_FETCH;
                        end
                        CLS_JR: begin
                            pc_write = 1'b1;
                            pc_src_c = PC_REG;
                            state_d  = S_FETCH;
                        end
                        default: state_d = S_WB;
                    endcase
                end
                S_MEM: begin
                    mem_req_c = 1'b1;
                    mem_we_c  = (cls == CLS_SW);
                    if (mem.mem_ack) begin
                        if (cls == CLS_SW) begin
                            pc_write = 1'b1;
                            state_d  = S_FETCH;
                        end else begin
                            state_d  = S_WB;
                        end
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    reg_dst_c  = (cls == CLS_JAL) ? RD_RA : (is_r_type ? RD_RD : RD_RT);
                    mem_to_reg = (cls == CLS_LW);
                    pc_src_c   = (cls == CLS_JAL) ? PC_JUMP : PC_SEQ;
                    pc_write   = 1'b1;
                    state_d    = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign mem.mem_req   = mem_req_c;
    assign mem.mem_we    = mem_we_c;
    assign pc_src        = pc_src_c;
    assign reg_dst       = reg_dst_c;
    assign instr_retired = pc_write;

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            state_q       <= S_FETCH;
            run_q         <= 1'b0;
            retired_count <= '0;
            illegal       <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (instr_retired) begin
                retired_count <= retired_count + COUNT_W'(1);
            end
            if (set_illegal) begin
                illegal <= 1'b1;
            end
        end
    end

endmodule
